rotor_stack_stepper: RTL

Parametrised N-rotor position register and stepping controller for the Enigma datapath. It replaces the single 0–25 rotor counter. It holds one position per rotor and advances the stack odometer-style on each debounced step request, carrying at per-rotor notch positions. It also supports synchronous bulk load of initial positions. Downstream substitution logic and the HEX/LED debug displays consume its packed position bus.

---
 rtl/rotor_stack_stepper_pkg.sv | 12 +
 rtl/rotor_stack_stepper_if.sv | 18 +
 rtl/sync_2ff.sv | 16 +
 rtl/rotor_stack_stepper.sv | 92 +++++++++
 4 files changed

// File: rtl/rotor_stack_stepper_pkg.sv
// Shared defaults, FSM state type and load-clamp helper for the rotor stack stepper.
package enigma_pkg;
  localparam int ALPHABET_DEF = 26;
  localparam int POS_W_DEF    = 5;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  // Out-of-range initial positions collapse to 0 rather than wrapping.
  function automatic int unsigned clamp_pos(input int unsigned p, input int unsigned alphabet);
    return (p >= alphabet) ? 32'd0 : p;
  endfunction
endpackage

// File: rtl/rotor_stack_stepper_if.sv
// Control/position bundle between the rotor stack stepper and its board-level driver.
interface rotor_stack_stepper_if #(
  parameter int N_ROTORS = 3,
  parameter int POS_W    = 5
);
  logic                      step_req;
  logic                      load;
  logic [N_ROTORS*POS_W-1:0] init_pos;
  logic [N_ROTORS*POS_W-1:0] pos;
  logic                      step_done;
  logic                      carry_out;
  logic                      busy;

  modport master (output step_req, load, init_pos,
                  input  pos, step_done, carry_out, busy);
  modport slave  (input  step_req, load, init_pos,
                  output pos, step_done, carry_out, busy);
endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/rotor_stack_stepper.sv
// N-rotor position register with odometer stepping, notch carry and bulk load.
// Define ROTOR_DOUBLE_STEP_EN to enable the historical middle-rotor double step.
module rotor_stack_stepper
  import enigma_pkg::*;
#(
  parameter int                        N_ROTORS  = 3,
  parameter int                        ALPHABET  = ALPHABET_DEF,
  parameter int                        POS_W     = POS_W_DEF,
  parameter logic [N_ROTORS*POS_W-1:0] NOTCH_POS = {5'd16, 5'd4, 5'd21}
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  rotor_stack_stepper_if.slave  bus
);
  localparam logic [POS_W-1:0] LAST = POS_W'(ALPHABET - 1);

  logic req_s, load_s;
  state_e state_q, state_d;
  logic [N_ROTORS-1:0][POS_W-1:0] pos_q, pos_d, step_pos, load_pos;
  logic [N_ROTORS-1:0] adv;
  logic step_done_q, step_done_d, carry_q, carry_d, wrap_top;

  sync_2ff u_sync_req  (.clk(CLOCK_50), .rst_n(resetn), .d_i(bus.step_req), .q_o(req_s));
  sync_2ff u_sync_load (.clk(CLOCK_50), .rst_n(resetn), .d_i(bus.load),     .q_o(load_s));

  // A rotor carries into the next only when it is itself stepping while on its notch.
  for (genvar i = 0; i < N_ROTORS; i++) begin : g_rotor
    if (i == 0) begin : g_fast
      assign adv[i] = 1'b1;
    end else begin : g_slow
      logic carry_in;
      assign carry_in = adv[i-1] && (pos_q[i-1] == NOTCH_POS[(i-1)*POS_W +: POS_W]);
`ifdef ROTOR_DOUBLE_STEP_EN
      if (i < N_ROTORS - 1) begin : g_dbl
        assign adv[i] = carry_in || (pos_q[i] == NOTCH_POS[i*POS_W +: POS_W]);
      end else begin : g_last
        assign adv[i] = carry_in;
      end
`else
      assign adv[i] = carry_in;
`endif
    end
    assign step_pos[i] = adv[i] ? ((pos_q[i] == LAST) ? '0 : pos_q[i] + POS_W'(1)) : pos_q[i];
    assign load_pos[i] = POS_W'(clamp_pos(32'(bus.init_pos[i*POS_W +: POS_W]), ALPHABET));
  end

  assign wrap_top = adv[N_ROTORS-1] && (pos_q[N_ROTORS-1] == LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      step_done_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      step_done_q <= step_done_d;
      carry_q     <= carry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    step_done_d = 1'b0;
    carry_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_s) begin
          pos_d   = load_pos;
          state_d = HOLD;
        end else if (req_s) begin
          pos_d       = step_pos;
          step_done_d = 1'b1;
          carry_d     = wrap_top;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (load_s)      pos_d   = load_pos;
        else if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pos       = pos_q;
  assign bus.step_done = step_done_q;
  assign bus.carry_out = carry_q;
  assign bus.busy      = (state_q == HOLD);
endmodule
